// File: rtl/hid_report_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : hid_report_monitor_if
// Description : Report bus from N_CH usb_hid_host cores into the monitor.
// Revision    : 1.0
// ============================================================================
interface hid_report_monitor_if #(
  parameter int N_CH         = 2,
  parameter int REPORT_BYTES = 8
) ();
  localparam int c_w = REPORT_BYTES * 8;

  logic [N_CH-1:0]     report_stb;
  logic [N_CH*c_w-1:0] report_data;
  logic [N_CH*2-1:0]   typ;
  logic [N_CH-1:0]     conerr;

  modport master (output report_stb, output report_data, output typ, output conerr);
  modport slave  (input  report_stb, input  report_data, input  typ, input  conerr);
endinterface
`default_nettype wire

// File: rtl/hid_report_monitor.sv
`default_nettype none
// ============================================================================
// Module      : hid_report_monitor
// Description : Per-channel HID report capture, counters, activity/error LEDs
//               and display-channel selection (fixed/scan/freeze/changes-only).
// Revision    : 1.0
// ============================================================================
module hid_report_monitor #(
  parameter int N_CH         = 2,
  parameter int REPORT_BYTES = 8,
  parameter int CNT_BITS     = 7,
  parameter int STRETCH_CYC  = 120000,
  parameter int SCAN_CYC     = 12000000,
  localparam int c_w  = REPORT_BYTES * 8,
  localparam int c_cb = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     usbclk,
  input  logic                     usbrst_n,
  hid_report_monitor_if.slave      hid,
  input  logic [1:0]               mode,
  input  logic [c_cb-1:0]          sel_ch,
  output logic [c_w-1:0]           disp_data,
  output logic [c_cb-1:0]          disp_ch,
  output logic [1:0]               disp_typ,
  output logic                     new_data,
  output logic [N_CH*CNT_BITS-1:0] report_cnt,
  output logic [N_CH-1:0]          act_led,
  output logic [N_CH-1:0]          err_led
);

  localparam logic [1:0] c_mode_scan = 2'd1;
  localparam logic [1:0] c_mode_frz  = 2'd2;
  localparam logic [1:0] c_mode_chg  = 2'd3;

  localparam int c_sw = $clog2(STRETCH_CYC + 1);
  localparam int c_sc = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;

  localparam logic [c_sw-1:0] c_stretch_load = c_sw'(STRETCH_CYC);
  localparam logic [c_sc-1:0] c_scan_last    = c_sc'(SCAN_CYC - 1);
  localparam logic [c_cb-1:0] c_dch_last     = c_cb'(N_CH - 1);

  logic [c_w-1:0]  w_cap [N_CH];
  logic [N_CH-1:0] w_upd;

  // ------------------------------------------------------------------
  // Per-channel capture, counter, activity stretch and error latch
  // ------------------------------------------------------------------
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [c_w-1:0]      r_cap;
    logic                r_upd;
    logic [CNT_BITS-1:0] r_cnt;
    logic [c_sw-1:0]     r_stretch;
    logic                r_act;
    logic                r_err;

    logic [c_w-1:0]  w_data;
    logic            w_stb;
    logic            w_we;
    logic [c_sw-1:0] w_stretch_nxt;

    assign w_data = hid.report_data[c*c_w +: c_w];
    assign w_stb  = hid.report_stb[c];
    // Changes-only mode drops reports identical to the last captured one
    assign w_we   = w_stb && ((mode != c_mode_chg) || (w_data != r_cap));

    assign w_stretch_nxt = w_stb                ? c_stretch_load :
                           (r_stretch != '0)    ? r_stretch - 1'b1 : '0;

    always_ff @(posedge usbclk or negedge usbrst_n) begin
      if (!usbrst_n) begin
        r_cap     <= '0;
        r_upd     <= 1'b0;
        r_cnt     <= '0;
        r_stretch <= '0;
        r_act     <= 1'b0;
        r_err     <= 1'b0;
      end else begin
        if (w_we) begin
          r_cap <= w_data;
        end
        r_upd <= w_we;
        if (w_stb) begin
          r_cnt <= r_cnt + 1'b1;
        end
        r_stretch <= w_stretch_nxt;
        r_act     <= (w_stretch_nxt != '0);
        if (hid.conerr[c]) begin
          r_err <= 1'b1;
        end else if (w_stb) begin
          r_err <= 1'b0;
        end
      end
    end

    assign w_cap[c] = r_cap;
    assign w_upd[c] = r_upd;
    assign report_cnt[c*CNT_BITS +: CNT_BITS] = r_cnt;
    assign act_led[c] = r_act;
    assign err_led[c] = r_err;
  end

  // ------------------------------------------------------------------
  // Display channel selection and display register
  // ------------------------------------------------------------------
  logic [c_cb-1:0] r_dch;
  logic            r_dch_chg;
  logic            r_frz;
  logic [c_sc-1:0] r_scan;
  logic [c_w-1:0]  r_disp;
  logic [1:0]      r_typ;
  logic            r_new;

  logic [c_w-1:0]  w_cap_sel;
  logic [1:0]      w_typ_sel;
  logic            w_upd_sel;
  logic [c_cb-1:0] w_dch_nxt;
  logic [c_sc-1:0] w_scan_nxt;
  logic            w_sel_ok;
  logic            w_unfreeze;
  logic            w_refresh;

  assign w_sel_ok   = (32'(sel_ch) < 32'(N_CH));
  assign w_unfreeze = r_frz && (mode != c_mode_frz);

  always_comb begin
    w_cap_sel = '0;
    w_typ_sel = '0;
    w_upd_sel = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (r_dch == c_cb'(c)) begin
        w_cap_sel = w_cap[c];
        w_typ_sel = hid.typ[c*2 +: 2];
        w_upd_sel = w_upd[c];
      end
    end
  end

  // The scan counter idles at zero outside scan mode, so entering scan
  // mode always starts a full dwell on the current channel.
  always_comb begin
    w_dch_nxt  = r_dch;
    w_scan_nxt = '0;
    case (mode)
      c_mode_scan: begin
        if (r_scan == c_scan_last) begin
          w_dch_nxt = (r_dch == c_dch_last) ? '0 : r_dch + 1'b1;
        end else begin
          w_scan_nxt = r_scan + 1'b1;
        end
      end
      c_mode_frz: begin
        w_dch_nxt = r_dch;
      end
      default: begin
        if (w_sel_ok) begin
          w_dch_nxt = sel_ch;
        end
      end
    endcase
  end

  assign w_refresh = (mode != c_mode_frz) && (w_upd_sel || r_dch_chg || w_unfreeze);

  always_ff @(posedge usbclk or negedge usbrst_n) begin
    if (!usbrst_n) begin
      r_dch     <= '0;
      r_dch_chg <= 1'b0;
      r_frz     <= 1'b0;
      r_scan    <= '0;
      r_disp    <= '0;
      r_typ     <= '0;
      r_new     <= 1'b0;
    end else begin
      r_dch     <= w_dch_nxt;
      r_dch_chg <= (w_dch_nxt != r_dch);
      r_frz     <= (mode == c_mode_frz);
      r_scan    <= w_scan_nxt;
      r_new     <= w_refresh;
      if (w_refresh) begin
        r_disp <= w_cap_sel;
        r_typ  <= w_typ_sel;
      end
    end
  end

  assign disp_data = r_disp;
  assign disp_ch   = r_dch;
  assign disp_typ  = r_typ;
  assign new_data  = r_new;

endmodule
`default_nettype wire

// File: tb/tb_hid_report_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_hid_report_monitor
// Description : Directed, table-driven bench for hid_report_monitor.
// Revision    : 1.0
// ============================================================================
module tb_hid_report_monitor;

  localparam logic [63:0] c_a = 64'h0000_0000_0004_0000;
  localparam logic [63:0] c_b = 64'h0000_0000_0005_0000;
  localparam logic [63:0] c_c = 64'h1122_3344_5566_7788;
  localparam logic [63:0] c_d = 64'h0000_0000_0029_0000;
  localparam logic [63:0] c_e = 64'h0000_0000_0006_0000;
  localparam logic [63:0] c_f = 64'h0000_0000_0007_0000;

  logic        usbclk = 1'b0;
  logic        usbrst_n;
  logic [1:0]  mode;
  logic [1:0]  sel_ch;
  logic [63:0] disp_data;
  logic [1:0]  disp_ch;
  logic [1:0]  disp_typ;
  logic        new_data;
  logic [20:0] report_cnt;
  logic [2:0]  act_led;
  logic [2:0]  err_led;

  int errors = 0;
  int checks = 0;

  hid_report_monitor_if #(.N_CH(3), .REPORT_BYTES(8)) hid ();

  hid_report_monitor #(
    .N_CH(3), .REPORT_BYTES(8), .CNT_BITS(7), .STRETCH_CYC(10), .SCAN_CYC(16)
  ) dut (
    .usbclk(usbclk), .usbrst_n(usbrst_n), .hid(hid), .mode(mode), .sel_ch(sel_ch),
    .disp_data(disp_data), .disp_ch(disp_ch), .disp_typ(disp_typ), .new_data(new_data),
    .report_cnt(report_cnt), .act_led(act_led), .err_led(err_led)
  );

  always #5 usbclk = ~usbclk;

  typedef struct {
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [2:0]  stb;
    logic [63:0] data;
    logic [2:0]  cerr;
    logic [63:0] e_disp;
    logic [1:0]  e_ch;
    logic        e_new;
    logic [1:0]  e_typ;
    logic [2:0]  e_act;
    logic [2:0]  e_err;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] m, input logic [1:0] s, input logic [2:0] stb,
                       input logic [63:0] d, input logic [2:0] ce);
    mode           = m;
    sel_ch         = s;
    hid.report_stb = stb;
    hid.conerr     = ce;
    for (int c = 0; c < 3; c++) hid.report_data[c*64 +: 64] = d;
  endtask

  task automatic tick();
    @(posedge usbclk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " disp_data"}, disp_data, 64'd0);
    check({tag, " disp_ch"}, 64'(disp_ch), 64'd0);
    check({tag, " disp_typ"}, 64'(disp_typ), 64'd0);
    check({tag, " new_data"}, 64'(new_data), 64'd0);
    check({tag, " report_cnt"}, 64'(report_cnt), 64'd0);
    check({tag, " act_led"}, 64'(act_led), 64'd0);
    check({tag, " err_led"}, 64'(err_led), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic act_ok;

    // mode, sel, stb, data, cerr | disp, ch, new, typ, act, err
    tbl[0]  = '{2'd0, 2'd0, 3'b001, c_a,   3'b000, 64'd0, 2'd0, 1'b0, 2'd0, 3'b001, 3'b000};
    tbl[1]  = '{2'd0, 2'd0, 3'b000, 64'd0, 3'b000, c_a,   2'd0, 1'b1, 2'd1, 3'b001, 3'b000};
    tbl[2]  = '{2'd0, 2'd0, 3'b000, 64'd0, 3'b000, c_a,   2'd0, 1'b0, 2'd1, 3'b001, 3'b000};
    tbl[3]  = '{2'd0, 2'd1, 3'b000, 64'd0, 3'b000, c_a,   2'd1, 1'b0, 2'd1, 3'b001, 3'b000};
    tbl[4]  = '{2'd0, 2'd1, 3'b000, 64'd0, 3'b000, 64'd0, 2'd1, 1'b1, 2'd2, 3'b001, 3'b000};
    tbl[5]  = '{2'd0, 2'd1, 3'b010, c_b,   3'b100, 64'd0, 2'd1, 1'b0, 2'd2, 3'b011, 3'b100};
    tbl[6]  = '{2'd0, 2'd1, 3'b000, 64'd0, 3'b000, c_b,   2'd1, 1'b1, 2'd2, 3'b011, 3'b100};
    tbl[7]  = '{2'd0, 2'd1, 3'b100, c_c,   3'b000, c_b,   2'd1, 1'b0, 2'd2, 3'b111, 3'b000};
    tbl[8]  = '{2'd0, 2'd3, 3'b000, 64'd0, 3'b000, c_b,   2'd1, 1'b0, 2'd2, 3'b111, 3'b000};
    tbl[9]  = '{2'd0, 2'd3, 3'b000, 64'd0, 3'b000, c_b,   2'd1, 1'b0, 2'd2, 3'b111, 3'b000};
    tbl[10] = '{2'd0, 2'd2, 3'b000, 64'd0, 3'b000, c_b,   2'd2, 1'b0, 2'd2, 3'b110, 3'b000};
    tbl[11] = '{2'd0, 2'd2, 3'b000, 64'd0, 3'b000, c_c,   2'd2, 1'b1, 2'd3, 3'b110, 3'b000};
    tbl[12] = '{2'd2, 2'd0, 3'b100, c_d,   3'b000, c_c,   2'd2, 1'b0, 2'd3, 3'b110, 3'b000};
    tbl[13] = '{2'd2, 2'd0, 3'b000, 64'd0, 3'b000, c_c,   2'd2, 1'b0, 2'd3, 3'b110, 3'b000};
    tbl[14] = '{2'd0, 2'd2, 3'b000, 64'd0, 3'b000, c_d,   2'd2, 1'b1, 2'd3, 3'b110, 3'b000};
    tbl[15] = '{2'd0, 2'd2, 3'b000, 64'd0, 3'b000, c_d,   2'd2, 1'b0, 2'd3, 3'b100, 3'b000};

    usbrst_n = 1'b0;
    hid.typ  = 6'b11_10_01;
    drive(2'd0, 2'd0, 3'b000, 64'd0, 3'b000);
    repeat (3) tick();
    check_all_zero("reset");
    usbrst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].mode, tbl[i].sel, tbl[i].stb, tbl[i].data, tbl[i].cerr);
      tick();
      check($sformatf("v%0d disp_data", i), disp_data, tbl[i].e_disp);
      check($sformatf("v%0d disp_ch", i), 64'(disp_ch), 64'(tbl[i].e_ch));
      check($sformatf("v%0d new_data", i), 64'(new_data), 64'(tbl[i].e_new));
      check($sformatf("v%0d disp_typ", i), 64'(disp_typ), 64'(tbl[i].e_typ));
      check($sformatf("v%0d act_led", i), 64'(act_led), 64'(tbl[i].e_act));
      check($sformatf("v%0d err_led", i), 64'(err_led), 64'(tbl[i].e_err));
    end
    drive(2'd0, 2'd2, 3'b000, 64'd0, 3'b000);
    check("table report_cnt", 64'(report_cnt), 64'({7'd2, 7'd1, 7'd1}));

    // Changes-only: three identical reports then a different one
    drive(2'd3, 2'd1, 3'b000, 64'd0, 3'b000);
    repeat (3) tick();
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      drive(2'd3, 2'd1, 3'b010, (k == 3) ? c_f : c_e, 3'b000);
      tick();
      pulses += int'(new_data);
      drive(2'd3, 2'd1, 3'b000, 64'd0, 3'b000);
      repeat (2) begin
        tick();
        pulses += int'(new_data);
      end
    end
    tick();
    pulses += int'(new_data);
    check("chg pulses", 64'(pulses), 64'd2);
    check("chg report_cnt1", 64'(report_cnt[13:7]), 64'd5);
    check("chg disp_data", disp_data, c_f);

    // Auto-scan: 16-cycle dwell per channel, then back to fixed mid-dwell
    drive(2'd0, 2'd0, 3'b000, 64'd0, 3'b000);
    repeat (2) tick();
    check("pre-scan disp_ch", 64'(disp_ch), 64'd0);
    drive(2'd1, 2'd0, 3'b000, 64'd0, 3'b000);
    for (int j = 1; j <= 50; j++) begin
      tick();
      check($sformatf("scan j%0d disp_ch", j), 64'(disp_ch), 64'((j / 16) % 3));
    end
    drive(2'd0, 2'd2, 3'b000, 64'd0, 3'b000);
    tick();
    check("scan exit disp_ch", 64'(disp_ch), 64'd2);

    // 128 strobes on ch0, 5 apart: counter wraps back, LED never drops
    act_ok = 1'b1;
    for (int k = 0; k < 128; k++) begin
      drive(2'd0, 2'd2, 3'b001, c_a, 3'b000);
      tick();
      if (act_led[0] !== 1'b1) act_ok = 1'b0;
      drive(2'd0, 2'd2, 3'b000, 64'd0, 3'b000);
      repeat (4) begin
        tick();
        if (act_led[0] !== 1'b1) act_ok = 1'b0;
      end
    end
    check("stretch continuous", 64'(act_ok), 64'd1);
    check("wrap report_cnt0", 64'(report_cnt[6:0]), 64'd1);
    repeat (5) tick();
    check("stretch last-high", 64'(act_led[0]), 64'd1);
    tick();
    check("stretch fall", 64'(act_led[0]), 64'd0);

    // Error latch: set wins over a simultaneous strobe, lone strobe clears
    drive(2'd0, 2'd2, 3'b001, c_a, 3'b001);
    tick();
    check("err set+stb", 64'(err_led[0]), 64'd1);
    drive(2'd0, 2'd2, 3'b000, 64'd0, 3'b000);
    repeat (2) tick();
    check("err sticky", 64'(err_led[0]), 64'd1);
    drive(2'd0, 2'd2, 3'b001, c_a, 3'b000);
    tick();
    check("err clear", 64'(err_led[0]), 64'd0);
    drive(2'd0, 2'd2, 3'b000, 64'd0, 3'b000);

    // Asynchronous reset mid-stretch, then a cold start
    repeat (2) tick();
    check("pre-reset act_led0", 64'(act_led[0]), 64'd1);
    #2 usbrst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    tick();
    usbrst_n = 1'b1;
    drive(2'd0, 2'd0, 3'b001, c_a, 3'b000);
    tick();
    check("cold report_cnt", 64'(report_cnt), 64'd1);
    check("cold disp_data t+1", disp_data, 64'd0);
    drive(2'd0, 2'd0, 3'b000, 64'd0, 3'b000);
    tick();
    check("cold disp_data", disp_data, c_a);
    check("cold new_data", 64'(new_data), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
